// File: rtl/regfile_pkg.sv
// Shared constants, helpers and types for the multi-port register file.
package regfile_pkg;

  localparam int unsigned XLEN_DEF  = 32;
  localparam int unsigned NREGS_DEF = 32;

  function automatic int unsigned addr_w(input int unsigned n);
    return unsigned'($clog2(n));
  endfunction

  localparam int unsigned AW_DEF = addr_w(NREGS_DEF);

  // Read-port request, kept for a future packed-port interface.
  typedef struct packed {
    logic [AW_DEF-1:0] addr;
    logic              used;
  } rd_port_t;

endpackage

// File: rtl/rf_scoreboard.sv
// Pending-write busy bits with flush > issue-set > writeback-clear priority,
// plus per-port busy lookup that hides producers completing this cycle.
module rf_scoreboard #(
  parameter int unsigned NREGS    = 32,
  parameter int unsigned NRD      = 2,
  parameter int unsigned AW       = 5,
  parameter int unsigned ZERO_REG = 1,
  parameter int unsigned BYPASS   = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              wr_en,
  input  logic [AW-1:0]     wr_addr,
  input  logic              iss_en,
  input  logic [AW-1:0]     iss_addr,
  input  logic              flush,
  input  logic [NRD*AW-1:0] rd_addr,
  output logic [NRD-1:0]    rd_busy
);

  logic [NREGS-1:0] busy_q;
  logic [NREGS-1:0] busy_d;

  // In range and not the hardwired zero register.
  function automatic logic addr_live(input logic [AW-1:0] a);
    return (32'(a) < NREGS) && !((ZERO_REG != 0) && (a == '0));
  endfunction

  always_comb begin
    busy_d = busy_q;
    if (flush) begin
      busy_d = '0;
    end else begin
      if (wr_en && addr_live(wr_addr)) busy_d[wr_addr] = 1'b0;
      if (iss_en && addr_live(iss_addr)) busy_d[iss_addr] = 1'b1;
    end
    if (ZERO_REG != 0) busy_d[0] = 1'b0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) busy_q <= '0;
    else        busy_q <= busy_d;
  end

  for (genvar i = 0; i < int'(NRD); i++) begin : g_rd
    logic [AW-1:0] a;
    logic          wr_hit;
    assign a       = rd_addr[i*AW +: AW];
    assign wr_hit  = (BYPASS != 0) && wr_en && (wr_addr == a);
    assign rd_busy[i] = addr_live(a) && busy_q[a] && !wr_hit;
  end

endmodule

// File: rtl/regfile_mp_sb.sv
// Multi-read-port register file with same-cycle write bypass and a RAW
// scoreboard; posedge write, async active-low reset, combinational reads.
module regfile_mp_sb
  import regfile_pkg::*;
#(
  parameter  int unsigned XLEN     = XLEN_DEF,
  parameter  int unsigned NREGS    = NREGS_DEF,
  parameter  int unsigned NRD      = 2,
  parameter  int unsigned ZERO_REG = 1,
  parameter  int unsigned BYPASS   = 1,
  localparam int unsigned AW       = addr_w(NREGS)
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                wr_en,
  input  logic [AW-1:0]       wr_addr,
  input  logic [XLEN-1:0]     wr_data,
  input  logic [NRD*AW-1:0]   rd_addr,
  input  logic [NRD-1:0]      rd_use,
  output logic [NRD*XLEN-1:0] rd_data,
  output logic [NRD-1:0]      rd_busy,
  output logic                hazard,
  input  logic                iss_en,
  input  logic [AW-1:0]       iss_addr,
  input  logic                flush
);

  logic [XLEN-1:0] regs_q [NREGS];
  logic            wr_ok;

  assign wr_ok = wr_en && (32'(wr_addr) < NREGS)
              && !((ZERO_REG != 0) && (wr_addr == '0));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned r = 0; r < NREGS; r++) regs_q[r] <= '0;
    end else if (wr_ok) begin
      regs_q[wr_addr] <= wr_data;
    end
  end

  // Per-port read: zero/out-of-range first, then bypass, then storage.
  for (genvar i = 0; i < int'(NRD); i++) begin : g_rd
    logic [AW-1:0]   a;
    logic [XLEN-1:0] val;
    assign a = rd_addr[i*AW +: AW];

    always_comb begin
      val = regs_q[a];
      if ((32'(a) >= NREGS) || ((ZERO_REG != 0) && (a == '0))) begin
        val = '0;
      end else if ((BYPASS != 0) && wr_ok && (wr_addr == a)) begin
        val = wr_data;
      end
    end

    assign rd_data[i*XLEN +: XLEN] = val;
  end

  rf_scoreboard #(
    .NREGS    (NREGS),
    .NRD      (NRD),
    .AW       (AW),
    .ZERO_REG (ZERO_REG),
    .BYPASS   (BYPASS)
  ) u_sb (
    .clk      (clk),
    .rst_n    (rst_n),
    .wr_en    (wr_en),
    .wr_addr  (wr_addr),
    .iss_en   (iss_en),
    .iss_addr (iss_addr),
    .flush    (flush),
    .rd_addr  (rd_addr),
    .rd_busy  (rd_busy)
  );

  assign hazard = |(rd_busy & rd_use);

endmodule

// File: tb/tb_regfile_mp_sb.sv
// Directed bench: default file, a no-bypass twin, and a 24-entry 3-port variant
// share the write/issue stimulus; expected values are hand-computed.
module tb_regfile_mp_sb;

  logic        clk;
  logic        rst_n;
  logic        wr_en;
  logic [4:0]  wr_addr;
  logic [31:0] wr_data;
  logic        iss_en;
  logic [4:0]  iss_addr;
  logic        flush;

  logic [9:0]  rd_addr;
  logic [1:0]  rd_use;
  logic [63:0] rd_data_a, rd_data_b;
  logic [1:0]  rd_busy_a, rd_busy_b;
  logic        hazard_a, hazard_b;

  logic [14:0] rd_addr_c;
  logic [2:0]  rd_use_c;
  logic [95:0] rd_data_c;
  logic [2:0]  rd_busy_c;
  logic        hazard_c;

  int compared = 0;
  int mismatched = 0;

  regfile_mp_sb dut_a (
    .clk(clk), .rst_n(rst_n), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .rd_addr(rd_addr), .rd_use(rd_use), .rd_data(rd_data_a), .rd_busy(rd_busy_a),
    .hazard(hazard_a), .iss_en(iss_en), .iss_addr(iss_addr), .flush(flush)
  );

  regfile_mp_sb #(.BYPASS(0)) dut_b (
    .clk(clk), .rst_n(rst_n), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .rd_addr(rd_addr), .rd_use(rd_use), .rd_data(rd_data_b), .rd_busy(rd_busy_b),
    .hazard(hazard_b), .iss_en(iss_en), .iss_addr(iss_addr), .flush(flush)
  );

  regfile_mp_sb #(.NREGS(24), .NRD(3)) dut_c (
    .clk(clk), .rst_n(rst_n), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .rd_addr(rd_addr_c), .rd_use(rd_use_c), .rd_data(rd_data_c), .rd_busy(rd_busy_c),
    .hazard(hazard_c), .iss_en(iss_en), .iss_addr(iss_addr), .flush(flush)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    wr_en    = 1'b0;
    iss_en   = 1'b0;
    flush    = 1'b0;
    rd_use   = '0;
    rd_use_c = '0;
  endtask

  initial begin
    rst_n = 1'b1;
    idle();
    wr_addr = '0; wr_data = '0; iss_addr = '0;
    rd_addr = '0; rd_addr_c = '0;
    #1 rst_n = 1'b0;
    #2;
    chk("rst_data", rd_data_a, 64'h0);
    chk("rst_busy_haz", {rd_busy_a, hazard_a}, 64'h0);
    @(posedge clk); @(posedge clk);
    #3 rst_n = 1'b1;
    tick();

    // Write x5 and mark it busy, then reset mid-cycle.
    wr_en = 1'b1; wr_addr = 5'd5; wr_data = 32'hDEADBEEF;
    iss_en = 1'b1; iss_addr = 5'd5;
    tick();
    idle();
    rd_addr = {5'd0, 5'd5};
    #1;
    chk("x5_written", rd_data_a[31:0], 64'hDEADBEEF);
    chk("x5_busy", rd_busy_a, 64'h1);
    #2 rst_n = 1'b0;
    #1;
    chk("x5_after_rst", rd_data_a[31:0], 64'h0);
    chk("busy_after_rst", rd_busy_a, 64'h0);
    tick();
    rst_n = 1'b1;
    tick();

    // Register zero ignores writes and issues.
    wr_en = 1'b1; wr_addr = 5'd0; wr_data = 32'h1234;
    iss_en = 1'b1; iss_addr = 5'd0;
    rd_addr = {5'd0, 5'd0};
    #2;
    chk("x0_same_cycle", rd_data_a[31:0], 64'h0);
    tick();
    idle();
    #2;
    chk("x0_next_data", rd_data_a[31:0], 64'h0);
    chk("x0_next_busy", rd_busy_a, 64'h0);

    // Bypass versus no-bypass.
    wr_en = 1'b1; wr_addr = 5'd7; wr_data = 32'h11111111;
    tick();
    wr_addr = 5'd7; wr_data = 32'hA5A5A5A5;
    rd_addr = {5'd7, 5'd0};
    #2;
    chk("byp_a", rd_data_a[63:32], 64'hA5A5A5A5);
    chk("byp_b_old", rd_data_b[63:32], 64'h11111111);
    tick();
    idle();
    #2;
    chk("byp_b_new", rd_data_b[63:32], 64'hA5A5A5A5);

    // RAW hazard on x3, resolved by writeback.
    iss_en = 1'b1; iss_addr = 5'd3;
    tick();
    idle();
    rd_addr = {5'd7, 5'd3};
    rd_use = 2'b01;
    #2;
    chk("raw_hazard", hazard_a, 64'h1);
    chk("raw_busy", rd_busy_a, 64'h1);
    rd_use = 2'b10;
    #1;
    chk("raw_unused_port", hazard_a, 64'h0);
    rd_use = 2'b01;
    wr_en = 1'b1; wr_addr = 5'd3; wr_data = 32'h42;
    #1;
    chk("raw_wb_haz_a", hazard_a, 64'h0);
    chk("raw_wb_data_a", rd_data_a[31:0], 64'h42);
    chk("raw_wb_haz_b", hazard_b, 64'h1);
    chk("raw_wb_data_b", rd_data_b[31:0], 64'h0);
    tick();
    idle();
    rd_use = 2'b01;
    #2;
    chk("raw_done_haz", {rd_busy_a, hazard_a}, 64'h0);
    chk("raw_done_data", rd_data_a[31:0], 64'h42);

    // Same-address issue and write: issue wins.
    iss_en = 1'b1; iss_addr = 5'd9;
    wr_en = 1'b1; wr_addr = 5'd9; wr_data = 32'h99;
    tick();
    idle();
    rd_addr = {5'd9, 5'd9};
    #2;
    chk("same_addr_busy", rd_busy_a, 64'h3);
    chk("same_addr_data", rd_data_a, {32'h99, 32'h99});
    iss_en = 1'b1; iss_addr = 5'd2;
    tick();
    idle();
    rd_addr = {5'd2, 5'd9};
    #2;
    chk("two_busy", rd_busy_a, 64'h3);

    // Flush with concurrent issue and write.
    flush = 1'b1;
    iss_en = 1'b1; iss_addr = 5'd4;
    wr_en = 1'b1; wr_addr = 5'd10; wr_data = 32'h10;
    tick();
    idle();
    rd_addr = {5'd2, 5'd9};
    #2;
    chk("flush_cleared", rd_busy_a, 64'h0);
    rd_addr = {5'd4, 5'd10};
    #1;
    chk("flush_iss_ignored", rd_busy_a, 64'h0);
    chk("flush_wr_kept", rd_data_a[31:0], 64'h10);

    // 24-entry, 3-port variant: out-of-range addresses.
    wr_en = 1'b1; wr_addr = 5'd30; wr_data = 32'hFFFF;
    iss_en = 1'b1; iss_addr = 5'd30;
    rd_addr_c = {5'd30, 5'd23, 5'd7};
    rd_addr = {5'd30, 5'd0};
    #2;
    chk("c_oor_byp", rd_data_c[95:64], 64'h0);
    chk("c_port0", rd_data_c[31:0], 64'hA5A5A5A5);
    tick();
    idle();
    #2;
    chk("c_oor_read", rd_data_c[95:64], 64'h0);
    chk("c_oor_busy", rd_busy_c, 64'h0);
    chk("a_x30_data", rd_data_a[63:32], 64'hFFFF);
    chk("a_x30_busy", rd_busy_a, 64'h2);

    wr_en = 1'b1; wr_addr = 5'd23; wr_data = 32'h2323;
    tick();
    idle();
    iss_en = 1'b1; iss_addr = 5'd23;
    tick();
    idle();
    rd_use_c = 3'b010;
    #2;
    chk("c_x23_data", rd_data_c[63:32], 64'h2323);
    chk("c_x23_hazard", hazard_c, 64'h1);
    chk("c_x23_busy", rd_busy_c, 64'h2);
    rd_use_c = 3'b101;
    #1;
    chk("c_unused_no_haz", hazard_c, 64'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
